// File: rtl/l1_norm_engine_pkg.sv
// ---------------------------------------------------------------------------
// l1_norm_engine_pkg
// Purpose: shared defaults, the accumulator width derivation and the FSM
//          state encoding for the L1-norm front end of the HWF kernel stage.
// Contents:
//   DEF_XLEN_PIXEL    default pixel width
//   DEF_NUM_OF_PIXELS default pixel pairs per support vector
//   normWidth()       smallest accumulator width that can never overflow
//   DEF_NORM_W        default accumulator / output width
//   state_t           IDLE=0, ACCUM=1, DONE=2
// ---------------------------------------------------------------------------
package l1_norm_engine_pkg;

    localparam int DEF_XLEN_PIXEL    = 8;
    localparam int DEF_NUM_OF_PIXELS = 4;

    // Each |a-b| fits in xlen bits, so nPix of them need clog2(nPix) extra bits.
    function automatic int normWidth(input int xlen, input int nPix);
        return xlen + ((nPix > 1) ? $clog2(nPix) : 0);
    endfunction

    localparam int DEF_NORM_W = normWidth(DEF_XLEN_PIXEL, DEF_NUM_OF_PIXELS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/l1_norm_engine_if.sv
// ---------------------------------------------------------------------------
// l1_norm_engine_if
// Purpose: bundles the pixel-pair input stream and the Ei result handshake.
// Signals:
//   pix_valid / pix_ready   pixel pair handshake (x_test, x_sv)
//   norm_out / norm_valid   scaled L1 norm, held until norm_ack
//   norm_ack                downstream consumed norm_out
//   norm_sat                saturation occurred in the presented result
// Modports:
//   master  upstream feeder / downstream consumer side (the environment)
//   slave   the norm engine itself
// ---------------------------------------------------------------------------
interface l1_norm_engine_if
    import l1_norm_engine_pkg::*;
#(
    parameter int XLEN_PIXEL = DEF_XLEN_PIXEL,
    parameter int NORM_W     = DEF_NORM_W
);

    logic                  pix_valid;
    logic                  pix_ready;
    logic [XLEN_PIXEL-1:0] x_test;
    logic [XLEN_PIXEL-1:0] x_sv;
    logic [NORM_W-1:0]     norm_out;
    logic                  norm_valid;
    logic                  norm_ack;
    logic                  norm_sat;

    modport master (
        output pix_valid, x_test, x_sv, norm_ack,
        input  pix_ready, norm_out, norm_valid, norm_sat
    );

    modport slave (
        input  pix_valid, x_test, x_sv, norm_ack,
        output pix_ready, norm_out, norm_valid, norm_sat
    );

endinterface

// File: rtl/l1_norm_engine_abs_diff.sv
// ---------------------------------------------------------------------------
// abs_diff
// Purpose: combinational |a_i - b_i| for unsigned pixels; shared with the
//          kernel stage.
// Ports:
//   a_i, b_i  in   XLEN_PIXEL  unsigned operands
//   diff_o    out  XLEN_PIXEL  unsigned magnitude of the difference
// ---------------------------------------------------------------------------
module abs_diff #(
    parameter int XLEN_PIXEL = 8
) (
    input  logic [XLEN_PIXEL-1:0] a_i,
    input  logic [XLEN_PIXEL-1:0] b_i,
    output logic [XLEN_PIXEL-1:0] diff_o
);

    logic signed [XLEN_PIXEL:0] diffSigned;

    assign diffSigned = $signed({1'b0, a_i}) - $signed({1'b0, b_i});

    // The magnitude never exceeds 2^XLEN_PIXEL-1, so negating only the low
    // bits of a negative difference is exact.
    assign diff_o = diffSigned[XLEN_PIXEL] ? (~diffSigned[XLEN_PIXEL-1:0] + XLEN_PIXEL'(1))
                                           : diffSigned[XLEN_PIXEL-1:0];

endmodule

// File: rtl/l1_norm_engine.sv
// ---------------------------------------------------------------------------
// l1_norm_engine
// Purpose: accumulates sum|x_sv - x_test| over NUM_OF_PIXELS pixel pairs of
//          one support vector, scales it by 2^GAMMA_SHIFT and presents it as
//          the Ei operand of the HWF kernel with a valid/ack handshake.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   stall_MEM  in   memory stall, freezes accumulation
//   start      in   begin a new vector (IDLE, or DONE together with norm_ack)
//   busy       out  engine not in IDLE
//   bus        l1_norm_engine_if.slave: pixel stream + result handshake
// ---------------------------------------------------------------------------
module l1_norm_engine
    import l1_norm_engine_pkg::*;
#(
    parameter int XLEN_PIXEL    = DEF_XLEN_PIXEL,
    parameter int NUM_OF_PIXELS = DEF_NUM_OF_PIXELS,
    parameter int NORM_W        = DEF_NORM_W,
    parameter int GAMMA_SHIFT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_MEM,
    input  logic             start,
    output logic             busy,
    l1_norm_engine_if.slave  bus
);

    localparam int                CNT_W    = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_OF_PIXELS - 1);
    localparam logic [NORM_W-1:0] NORM_MAX = '1;
    localparam int                SHIFT_W  = NORM_W + GAMMA_SHIFT;

    state_t              state_q, state_d;
    logic [NORM_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                accSat_q, accSat_d;

    logic [XLEN_PIXEL-1:0] pixDiff;
    logic [NORM_W:0]       sumWide;
    logic [NORM_W-1:0]     sumSat;
    logic                  sumOvf;
    logic [SHIFT_W-1:0]    shiftWide;
    logic                  shiftOvf;
    logic [NORM_W-1:0]     normScaled;
    logic                  accept;

    abs_diff #(
        .XLEN_PIXEL (XLEN_PIXEL)
    ) uAbsDiff (
        .a_i    (bus.x_sv),
        .b_i    (bus.x_test),
        .diff_o (pixDiff)
    );

    // One spare bit catches overflow of the running sum.
    assign sumWide = {1'b0, acc_q} + (NORM_W + 1)'(pixDiff);
    assign sumOvf  = sumWide[NORM_W];
    assign sumSat  = sumOvf ? NORM_MAX : sumWide[NORM_W-1:0];

    // Any bit shifted above NORM_W means the scaled result does not fit.
    assign shiftWide  = SHIFT_W'(acc_q) << GAMMA_SHIFT;
    assign shiftOvf   = (shiftWide >> NORM_W) != '0;
    assign normScaled = shiftOvf ? NORM_MAX : shiftWide[NORM_W-1:0];

    assign accept = (state_q == ACCUM) && !stall_MEM && bus.pix_valid;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            accSat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            accSat_q <= accSat_d;
        end
    end

    // Next state and datapath update. Starting a vector (from IDLE, or from
    // DONE with a same-cycle ack) always clears the accumulator and counter.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        accSat_d = accSat_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ACCUM;
                    acc_d    = '0;
                    cnt_d    = '0;
                    accSat_d = 1'b0;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d    = sumSat;
                    accSat_d = accSat_q | sumOvf;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.norm_ack) begin
                    if (start) begin
                        state_d  = ACCUM;
                        acc_d    = '0;
                        cnt_d    = '0;
                        accSat_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state so that reset clears them at once.
    always_comb begin
        bus.pix_ready  = (state_q == ACCUM) && !stall_MEM;
        bus.norm_valid = (state_q == DONE);
        bus.norm_out   = (state_q == DONE) ? normScaled : '0;
        bus.norm_sat   = (state_q == DONE) && (accSat_q || shiftOvf);
        busy           = (state_q != IDLE);
    end

endmodule

// File: tb/tb_l1_norm_engine.sv
// ---------------------------------------------------------------------------
// tb_l1_norm_engine
// Three engines share one stimulus stream: A (NORM_W=10, GAMMA_SHIFT=0),
// B (NORM_W=9, GAMMA_SHIFT=0) and C (NORM_W=10, GAMMA_SHIFT=1). Expected
// results come from a plain-arithmetic model of the scaled, saturated L1 sum.
// ---------------------------------------------------------------------------
module tb_l1_norm_engine;

    localparam int NPIX = 4;

    logic clk = 1'b0;
    logic rst;
    logic stallMem;
    logic startIn;
    logic pixValid;
    logic normAck;
    logic [7:0] xTest;
    logic [7:0] xSv;
    logic busyA, busyB, busyC;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l1_norm_engine_if #(.XLEN_PIXEL(8), .NORM_W(10)) busA ();
    l1_norm_engine_if #(.XLEN_PIXEL(8), .NORM_W(9))  busB ();
    l1_norm_engine_if #(.XLEN_PIXEL(8), .NORM_W(10)) busC ();

    assign busA.pix_valid = pixValid;
    assign busA.x_test    = xTest;
    assign busA.x_sv      = xSv;
    assign busA.norm_ack  = normAck;
    assign busB.pix_valid = pixValid;
    assign busB.x_test    = xTest;
    assign busB.x_sv      = xSv;
    assign busB.norm_ack  = normAck;
    assign busC.pix_valid = pixValid;
    assign busC.x_test    = xTest;
    assign busC.x_sv      = xSv;
    assign busC.norm_ack  = normAck;

    l1_norm_engine #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(NPIX), .NORM_W(10), .GAMMA_SHIFT(0)) dutA (
        .clk(clk), .rst(rst), .stall_MEM(stallMem), .start(startIn), .busy(busyA), .bus(busA)
    );
    l1_norm_engine #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(NPIX), .NORM_W(9), .GAMMA_SHIFT(0)) dutB (
        .clk(clk), .rst(rst), .stall_MEM(stallMem), .start(startIn), .busy(busyB), .bus(busB)
    );
    l1_norm_engine #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(NPIX), .NORM_W(10), .GAMMA_SHIFT(1)) dutC (
        .clk(clk), .rst(rst), .stall_MEM(stallMem), .start(startIn), .busy(busyC), .bus(busC)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: plain sum of absolute differences, then scale and clamp.
    function automatic int refSum(input int xt[NPIX], input int xs[NPIX]);
        int s = 0;
        for (int i = 0; i < NPIX; i++) begin
            s += (xs[i] > xt[i]) ? (xs[i] - xt[i]) : (xt[i] - xs[i]);
        end
        return s;
    endfunction

    function automatic int refOut(input int sum, input int w, input int g);
        int scaled = sum * (1 << g);
        int maxVal = (1 << w) - 1;
        return (scaled > maxVal) ? maxVal : scaled;
    endfunction

    function automatic int refSat(input int sum, input int w, input int g);
        return (sum * (1 << g) > (1 << w) - 1) ? 1 : 0;
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busyA"},  busyA, 0);
        checkOutput({tag, "_busyB"},  busyB, 0);
        checkOutput({tag, "_busyC"},  busyC, 0);
        checkOutput({tag, "_ready"},  busA.pix_ready, 0);
        checkOutput({tag, "_validA"}, busA.norm_valid, 0);
        checkOutput({tag, "_validC"}, busC.norm_valid, 0);
        checkOutput({tag, "_outA"},   busA.norm_out, 0);
        checkOutput({tag, "_satB"},   busB.norm_sat, 0);
    endtask

    task automatic checkDone(input string tag, input int sum);
        checkOutput({tag, "_validA"}, busA.norm_valid, 1);
        checkOutput({tag, "_validB"}, busB.norm_valid, 1);
        checkOutput({tag, "_validC"}, busC.norm_valid, 1);
        checkOutput({tag, "_outA"},   busA.norm_out, refOut(sum, 10, 0));
        checkOutput({tag, "_outB"},   busB.norm_out, refOut(sum, 9, 0));
        checkOutput({tag, "_outC"},   busC.norm_out, refOut(sum, 10, 1));
        checkOutput({tag, "_satA"},   busA.norm_sat, refSat(sum, 10, 0));
        checkOutput({tag, "_satB"},   busB.norm_sat, refSat(sum, 9, 0));
        checkOutput({tag, "_satC"},   busC.norm_sat, refSat(sum, 10, 1));
    endtask

    // Streams one vector. Stalls are random (stallPct) plus forcedStall cycles
    // right after the 2nd accept; start/norm_ack toggle randomly since both
    // must be ignored in ACCUM. Ends one cycle after the last accept.
    task automatic applyStimulus(input int xt[NPIX], input int xs[NPIX], input int stallPct,
                                 input int forcedStall, input bit inAccum, input bit validGaps);
        int idx    = 0;
        int budget = 0;
        int forced = forcedStall;
        if (!inAccum) begin
            @(negedge clk);
            startIn = 1'b1;
            @(posedge clk);
        end
        while (idx < NPIX && budget < 200) begin
            @(negedge clk);
            if (idx == 2 && forced > 0) begin
                stallMem = 1'b1;
                forced--;
            end else begin
                stallMem = ($urandom_range(99) < stallPct);
            end
            pixValid = validGaps ? ($urandom_range(3) != 0) : 1'b1;
            startIn  = 1'($urandom_range(1));
            normAck  = 1'($urandom_range(1));
            xTest    = 8'(xt[idx]);
            xSv      = 8'(xs[idx]);
            #1;
            checkOutput("pix_ready", busA.pix_ready, !stallMem);
            checkOutput("busy_accum", busyB, 1);
            checkOutput("no_valid_accum", busC.norm_valid, 0);
            @(posedge clk);
            if (pixValid && !stallMem) idx++;
            budget++;
        end
        if (idx < NPIX) checkOutput("accept_budget", idx, NPIX);
        @(negedge clk);
        pixValid = 1'b0;
        startIn  = 1'b0;
        normAck  = 1'b0;
        stallMem = 1'($urandom_range(1));
        #1;
        checkDone("done", refSum(xt, xs));
    endtask

    // Holds the result unacknowledged, then acks (optionally with start).
    task automatic holdAndAck(input int sum, input int holdCycles, input bit withStart);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            normAck  = 1'b0;
            stallMem = 1'($urandom_range(1));
            pixValid = 1'($urandom_range(1));
            #1;
            checkDone("hold", sum);
        end
        @(negedge clk);
        normAck  = 1'b1;
        startIn  = withStart;
        pixValid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ack_valid_drop", busA.norm_valid, 0);
        checkOutput("ack_busy", busyA, withStart);
        checkOutput("ack_busy_c", busyC, withStart);
        normAck = 1'b0;
        startIn = 1'b0;
    endtask

    task automatic runVector(input int xt[NPIX], input int xs[NPIX], input int stallPct,
                             input int forcedStall, input int holdCycles, input bit inAccum,
                             input bit withStart);
        applyStimulus(xt, xs, stallPct, forcedStall, inAccum, stallPct != 0);
        holdAndAck(refSum(xt, xs), holdCycles, withStart);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int xt[NPIX];
        int xs[NPIX];
        bit chained;

        rst      = 1'b1;
        stallMem = 1'b0;
        startIn  = 1'b0;
        pixValid = 1'b0;
        normAck  = 1'b0;
        xTest    = '0;
        xSv      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdle("reset");
        rst = 1'b0;

        // pix_valid and norm_ack in IDLE are ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pixValid = 1'b1;
            normAck  = 1'b1;
            xTest    = 8'd9;
            xSv      = 8'd1;
            #1;
            checkIdle("idle_ignore");
        end
        @(negedge clk);
        pixValid = 1'b0;
        normAck  = 1'b0;

        // Basic vector: 7 + 7 + 200 + 0 = 214.
        xt = '{10, 3, 200, 7};
        xs = '{3, 10, 0, 7};
        runVector(xt, xs, 0, 0, 0, 1'b0, 1'b0);

        // Same vector with a 3-cycle stall after the 2nd pixel.
        runVector(xt, xs, 0, 3, 0, 1'b0, 1'b0);

        // Saturating sum: 4 * 255 = 1020.
        xt = '{255, 255, 255, 255};
        xs = '{0, 0, 0, 0};
        runVector(xt, xs, 0, 0, 0, 1'b0, 1'b0);

        // Sum 300: fits everywhere, scaled to 600 by engine C.
        xt = '{100, 0, 50, 0};
        xs = '{0, 100, 0, 50};
        runVector(xt, xs, 0, 0, 5, 1'b0, 1'b1);

        // Back-to-back second vector directly from DONE: sum 4.
        xt = '{1, 1, 1, 1};
        xs = '{2, 2, 2, 2};
        runVector(xt, xs, 0, 0, 0, 1'b1, 1'b0);

        // Reset in the middle of a vector.
        @(negedge clk);
        startIn = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            startIn  = 1'b0;
            stallMem = 1'b0;
            pixValid = 1'b1;
            xTest    = 8'd0;
            xSv      = 8'd250;
            @(posedge clk);
        end
        @(negedge clk);
        pixValid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkIdle("async_reset");
        @(negedge clk);
        rst = 1'b0;
        xt = '{0, 0, 0, 0};
        xs = '{5, 5, 5, 5};
        runVector(xt, xs, 0, 0, 0, 1'b0, 1'b0);

        // Randomized vectors with stalls, valid gaps, holds and chaining.
        chained = 1'b0;
        for (int v = 0; v < 30; v++) begin
            bit nextChain;
            for (int i = 0; i < NPIX; i++) begin
                xt[i] = $urandom_range(255);
                xs[i] = ($urandom_range(7) == 0) ? xt[i] : $urandom_range(255);
            end
            if ($urandom_range(5) == 0) begin
                xt = '{255, 0, 255, 0};
                xs = '{0, 255, 0, 255};
            end
            nextChain = 1'($urandom_range(1));
            runVector(xt, xs, $urandom_range(40), 0, $urandom_range(3), chained, nextChain);
            chained = nextChain;
        end
        if (chained) begin
            xt = '{0, 0, 0, 0};
            xs = '{0, 0, 0, 0};
            runVector(xt, xs, 0, 0, 0, 1'b1, 1'b0);
        end

        @(negedge clk);
        checkIdle("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
